// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
//   cla_op_t : operation select (ADD = 0, SUB = 1)
//   GRP_W    : width of one lookahead group in bits
package cla_pkg;

  localparam int GRP_W = 4;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } cla_op_t;

endpackage

// File: rtl/cla_group.sv
// 4-bit carry-lookahead group (purely combinational).
// Ports:
//   x, y : group operand slices
//   cin  : carry into the group
//   s    : group sum
//   g    : group generate (group produces a carry on its own)
//   p    : group propagate (AND of bitwise x ^ y)
module cla_group
  import cla_pkg::*;
(
  input  logic [GRP_W-1:0] x,
  input  logic [GRP_W-1:0] y,
  input  logic             cin,
  output logic [GRP_W-1:0] s,
  output logic             g,
  output logic             p
);

  logic [GRP_W-1:0] gen;
  logic [GRP_W-1:0] prop;
  logic [GRP_W-1:0] c;

  assign gen  = x & y;
  assign prop = x ^ y;

  // Bit carries in flattened lookahead form rather than rippled.
  assign c[0] = cin;
  assign c[1] = gen[0] | (prop[0] & cin);
  assign c[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & cin);
  assign c[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
              | (prop[2] & prop[1] & prop[0] & cin);

  assign s = prop ^ c;
  assign g = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
           | (prop[3] & prop[2] & prop[1] & gen[0]);
  assign p = &prop;

endmodule

// File: rtl/pipe_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor.
// Parameters:
//   WIDTH  : operand/result width, multiple of 4 in 4..64
//   STAGES : pipeline depth in cycles, must divide WIDTH/4
// Ports:
//   Clk, Reset_n         : rising-edge clock, asynchronous active-low reset
//   Clear                : synchronous flush of every stage valid bit
//   in_valid, in_ready   : upstream handshake
//   A, B, Cin, Op        : operands, carry-in (ignored for SUB), ADD/SUB select
//   out_valid, out_ready : downstream handshake
//   Sum, CO, OVF         : result, carry out of MSB (SUB: 1 = no borrow),
//                          signed overflow
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. in_ready = !out_valid | out_ready, so the whole pipe advances together
// or holds together; while out_valid & !out_ready nothing moves and the
// outputs are stable. A pop and a push on the same edge both take effect.
module pipe_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  cla_op_t          Op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             CO,
  output logic             OVF
);

  localparam int NGRP = WIDTH / GRP_W;
  localparam int GPS  = NGRP / STAGES;   // groups handled per stage
  localparam int SW   = GPS * GRP_W;     // bits handled per stage

  if ((WIDTH % GRP_W) != 0 || WIDTH < 4 || WIDTH > 64 || STAGES < 1
      || (NGRP % STAGES) != 0) begin : g_param_check
    $error("pipe_cla_adder: illegal WIDTH/STAGES combination");
  end

  // Subtraction is A + ~B + 1; Cin only matters for ADD.
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  assign b_eff = (Op == SUB) ? ~B : B;
  assign c0    = (Op == SUB) ? 1'b1 : Cin;

  logic             advance;
  logic             flush;
  logic [WIDTH-1:0] stg_a [STAGES];
  logic [WIDTH-1:0] stg_b [STAGES];
  logic [WIDTH-1:0] stg_s [STAGES];
  logic [STAGES-1:0] stg_v;
  logic [STAGES-1:0] stg_c;
  logic             ovf_o;

  assign out_valid = stg_v[STAGES-1];
  assign in_ready  = !out_valid | out_ready;
  assign advance   = in_ready;
  assign flush     = Clear;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SW;

    logic [WIDTH-1:0] a_in, b_in, s_in, s_nx;
    logic             c_in, v_in;
    logic [GPS:0]     gc;
    logic [SW-1:0]    gs;
    logic [GPS-1:0]   gg, gp;
    logic [WIDTH-1:0] a_r, b_r, s_r;
    logic             c_r, v_r;

    if (k == 0) begin : g_head
      assign a_in = A;
      assign b_in = b_eff;
      assign s_in = '0;
      assign c_in = c0;
      assign v_in = in_valid;
    end else begin : g_body
      assign a_in = stg_a[k-1];
      assign b_in = stg_b[k-1];
      assign s_in = stg_s[k-1];
      assign c_in = stg_c[k-1];
      assign v_in = stg_v[k-1];
    end

    assign gc[0] = c_in;
    for (genvar j = 0; j < GPS; j++) begin : g_grp
      cla_group u_grp (
        .x   (a_in[LO + j*GRP_W +: GRP_W]),
        .y   (b_in[LO + j*GRP_W +: GRP_W]),
        .cin (gc[j]),
        .s   (gs[j*GRP_W +: GRP_W]),
        .g   (gg[j]),
        .p   (gp[j])
      );
      assign gc[j+1] = gg[j] | (gp[j] & gc[j]);
    end

    // Lower bits were finished by earlier stages; this stage fills its slice.
    always_comb begin
      s_nx = s_in;
      s_nx[LO +: SW] = gs;
    end

    // Clear drops valid bits only; data regs simply hold.
    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        v_r <= 1'b0;
        c_r <= 1'b0;
        a_r <= '0;
        b_r <= '0;
        s_r <= '0;
      end else if (flush) begin
        v_r <= 1'b0;
      end else if (advance) begin
        v_r <= v_in;
        c_r <= gc[GPS];
        a_r <= a_in;
        b_r <= b_in;
        s_r <= s_nx;
      end
    end

    assign stg_a[k] = a_r;
    assign stg_b[k] = b_r;
    assign stg_s[k] = s_r;
    assign stg_c[k] = c_r;
    assign stg_v[k] = v_r;

    if (k == STAGES-1) begin : g_tail
      logic ovf_r;
      // Carry into the MSB is recovered as sum ^ a ^ b at that bit.
      always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
          ovf_r <= 1'b0;
        end else if (advance && !flush) begin
          ovf_r <= gs[SW-1] ^ a_in[WIDTH-1] ^ b_in[WIDTH-1] ^ gc[GPS];
        end
      end
      assign ovf_o = ovf_r;
    end
  end

  assign Sum = stg_s[STAGES-1];
  assign CO  = stg_c[STAGES-1];
  assign OVF = ovf_o;

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Self-checking bench for pipe_cla_adder (WIDTH=16, STAGES=2).
module tb_pipe_cla_adder;
  import cla_pkg::*;

  localparam int WIDTH  = 16;
  localparam int STAGES = 2;

  logic             Clk = 1'b0;
  logic             Reset_n;
  logic             Clear;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A, B;
  logic             Cin;
  cla_op_t          Op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             CO;
  logic             OVF;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int pops   = 0;

  logic [WIDTH+1:0] exp_q [$];   // {sum, co, ovf}
  int               acc_q [$];   // cycle of acceptance

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  pipe_cla_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Clear     (Clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .Op        (Op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .CO        (CO),
    .OVF       (OVF)
  );

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a, b,
                                             input logic cin, input logic op);
    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] bb;
    logic             c0, ovf;
    bb  = op ? ~b : b;
    c0  = op ? 1'b1 : cin;
    t   = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, c0};
    // Signed overflow: operands agree in sign, result does not.
    ovf = (a[WIDTH-1] == bb[WIDTH-1]) && (t[WIDTH-1] != a[WIDTH-1]);
    return {t[WIDTH-1:0], t[WIDTH], ovf};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 16'hFFFF;
      1:       return 16'h8000;
      2:       return 16'h7FFF;
      3:       return 16'h0000;
      default: return 16'($urandom_range(0, 16'hFFFF));
    endcase
  endfunction

  // ---------------- scoreboard / compare process ----------------
  logic             hold_pend = 1'b0;
  logic [WIDTH+1:0] hold_snap;

  always @(negedge Clk) begin
    if (!Reset_n) begin
      exp_q.delete();
      acc_q.delete();
      hold_pend = 1'b0;
      check("reset_out_valid", out_valid, 0);
    end else begin
      check("in_ready_rule", in_ready, !out_valid | out_ready);
      if (hold_pend)
        check("hold_stable", {out_valid, Sum, CO, OVF}, {1'b1, hold_snap});
      if (Clear) begin
        exp_q.delete();
        acc_q.delete();
        hold_pend = 1'b0;
      end else begin
        if (out_valid && out_ready) begin
          pops++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out got=%0h exp=none", {Sum, CO, OVF});
          end else begin
            logic [WIDTH+1:0] e;
            int a;
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            check("result", {Sum, CO, OVF}, e);
            check("min_latency", ((cyc - a) >= STAGES) ? 1 : 0, 1);
          end
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(model(A, B, Cin, Op));
          acc_q.push_back(cyc);
        end
        hold_pend = out_valid && !out_ready;
        hold_snap = {Sum, CO, OVF};
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drain();
    int n;
    @(posedge Clk); #1;
    in_valid  = 1'b0;
    Clear     = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 20) begin
      @(posedge Clk); #1;
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    check("drain_idle", out_valid, 0);
  endtask

  task automatic directed(input logic [WIDTH-1:0] a, b, input logic cin, input cla_op_t op,
                          input logic [WIDTH-1:0] es, input logic eco, input logic eovf);
    int lat;
    lat = 0;
    drain();
    @(posedge Clk); #1;
    in_valid = 1'b1; A = a; B = b; Cin = cin; Op = op;
    for (int n = 1; n <= 8; n++) begin
      @(posedge Clk); #1;
      in_valid = 1'b0;
      @(negedge Clk);
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    check("dir_latency", lat, STAGES);
    check("dir_result", {Sum, CO, OVF}, {es, eco, eovf});
  endtask

  task automatic drive_random();
    in_valid = 1'b1;
    A   = rand_operand();
    B   = rand_operand();
    Cin = 1'($urandom_range(0, 1));
    Op  = cla_op_t'($urandom_range(0, 1));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int pops0;
    Reset_n = 1'b0; Clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; Cin = 1'b0; Op = ADD;

    // Hand-computed pins on the model itself.
    check("pin_add_wrap", model(16'hFFFF, 16'h0001, 1'b0, 1'b0), {16'h0000, 1'b1, 1'b0});
    check("pin_add_ovf",  model(16'h7FFF, 16'h0001, 1'b0, 1'b0), {16'h8000, 1'b0, 1'b1});
    check("pin_sub_neg",  model(16'h0005, 16'h0007, 1'b1, 1'b1), {16'hFFFE, 1'b0, 1'b0});

    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", Sum, 0);
    check("rst_co", CO, 0);
    check("rst_ovf", OVF, 0);
    check("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;

    // Directed corner operations.
    directed(16'hFFFF, 16'h0001, 1'b0, ADD, 16'h0000, 1'b1, 1'b0);
    directed(16'h7FFF, 16'h0001, 1'b0, ADD, 16'h8000, 1'b0, 1'b1);
    directed(16'h0005, 16'h0007, 1'b0, SUB, 16'hFFFE, 1'b0, 1'b0);
    directed(16'h0005, 16'h0007, 1'b1, SUB, 16'hFFFE, 1'b0, 1'b0);
    directed(16'h1234, 16'h0FFF, 1'b1, ADD, 16'h2234, 1'b0, 1'b0);
    directed(16'h8000, 16'h0001, 1'b0, SUB, 16'h7FFF, 1'b1, 1'b1);

    // Back-to-back ADDs: results on cycles 2..9, in order.
    drain();
    for (int c = 0; c < 12; c++) begin
      @(posedge Clk); #1;
      if (c < 8) begin
        drive_random();
        Op = ADD;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge Clk);
      check("b2b_out_valid", out_valid, (c >= 2 && c <= 9) ? 1 : 0);
    end
    drain();

    // Stall with the pipe full.
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge Clk); #1;
      drive_random();
    end
    @(posedge Clk); #1;
    in_valid = 1'b0;
    pops0 = pops;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      @(posedge Clk); #1;
    end
    drain();
    check("stall_pop_count", pops - pops0, STAGES);

    // Clear together with in_valid drops the input.
    @(posedge Clk); #1;
    drive_random();
    Clear = 1'b1;
    @(posedge Clk); #1;
    Clear = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk);
      check("clear_in_out_valid", out_valid, 0);
      @(posedge Clk); #1;
    end

    // Clear with one operation in flight.
    drive_random();
    @(posedge Clk); #1;
    in_valid = 1'b0;
    Clear = 1'b1;
    @(posedge Clk); #1;
    Clear = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      check("clear_flight_out_valid", out_valid, 0);
      @(posedge Clk); #1;
    end
    drain();

    // Reset pulsed mid-stream.
    for (int c = 0; c < 4; c++) begin
      @(posedge Clk); #1;
      drive_random();
    end
    @(posedge Clk); #1;
    in_valid = 1'b0;
    #2 Reset_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum", Sum, 0);
    check("midrst_co", CO, 0);
    check("midrst_ovf", OVF, 0);
    check("midrst_in_ready", in_ready, 1);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge Clk);
      check("postrst_out_valid", out_valid, 0);
    end
    directed(16'h00FF, 16'h0F01, 1'b0, ADD, 16'h1000, 1'b0, 1'b0);

    // Randomized traffic with random backpressure and occasional Clear.
    for (int c = 0; c < 400; c++) begin
      @(posedge Clk); #1;
      if ($urandom_range(0, 9) < 7) drive_random();
      else in_valid = 1'b0;
      out_ready = ($urandom_range(0, 9) < 7);
      Clear     = ($urandom_range(0, 49) == 0);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_cla_adder.md
PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width; legal values are multiples of 4, from 4 to 64.
REQ-002 SHALL have parameter STAGES, default 2, pipeline depth in cycles; it SHALL divide NGRP = WIDTH/4.
REQ-003 SHALL have port Clk, input, 1, sole clock; rising edge.
REQ-004 SHALL have port Reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port Clear, input, 1, synchronous pipeline flush.
REQ-006 SHALL have port in_valid / in_ready, input / output, 1 / 1, upstream handshake.
REQ-007 SHALL have port A and B, input, WIDTH each, operands.
REQ-008 SHALL have port Cin, input, 1, carry-in (ignored when Op=SUB).
REQ-009 SHALL have port Op, input, cla_op_t (1 bit), ADD=0, SUB=1.
REQ-010 SHALL have port out_valid / out_ready, output / input, 1 / 1, downstream handshake.
REQ-011 SHALL have port Sum, output, WIDTH, result.
REQ-012 SHALL have port CO, output, 1, carry out of MSB (SUB: 1 = no borrow).
REQ-013 SHALL have port OVF, output, 1, two's-complement signed overflow.

Function
REQ-014 SHALL compute Sum = A + B' + c0 with B' = B, c0 = Cin for ADD, and B' = ~B, c0 = 1 for SUB.
REQ-015 SHALL use 4-bit groups producing group generate G and propagate P (P = AND of bitwise xor); carry into group k+1 SHALL be G[k] | (P[k] & C[k]).
REQ-016 SHALL assign each stage NGRP/STAGES consecutive groups, LSB groups in stage 0; the inter-stage register SHALL carry the group carry, completed sums and unprocessed operand slices.
REQ-017 SHALL have latency exactly STAGES cycles from accepted input (in_valid & in_ready at an edge) to out_valid with no stall.
REQ-018 SHALL sustain throughput of one operation per cycle when out_ready is held high.
REQ-019 SHALL drive in_ready = !out_valid | out_ready (whole-pipe stall); while stalled, every stage register SHALL hold.
REQ-020 SHALL keep Sum/CO/OVF/out_valid stable while out_valid & !out_ready; an output handshake SHALL complete on an edge where out_valid & out_ready.
REQ-021 SHALL compute OVF = carry into MSB xor CO.
REQ-022 SHALL, on Clear = 1 at an edge, zero all stage valid bits, accept nothing, and take priority over in_valid in the same cycle.
REQ-023 SHALL, on simultaneous output pop and input accept, let both occur; no bubble is inserted.
REQ-024 SHALL, for STAGES = 1, behave as a registered adder with latency 1.

Reset
REQ-025 SHALL, while Reset_n = 0, asynchronously force out_valid = 0, Sum = 0, CO = 0, OVF = 0 and all stage valid bits to 0.
REQ-026 SHALL have in_ready = 1 during and after reset; reset mid-operation discards in-flight data and produces no spurious out_valid.
REQ-027 SHALL keep Reset_n deassertion synchronisation outside this block.

Structure
REQ-028 SHALL keep in shared package cla_pkg: cla_op_t enum (ADD, SUB) and localparam GRP_W = 4.
REQ-029 SHALL use one combinational sub-module, cla_group (4-bit x, y, cin -> s, g, p), instantiated NGRP times.
REQ-030 SHALL flag WIDTH % 4 != 0 or NGRP % STAGES != 0 at elaboration.

Verification (WIDTH=16, STAGES=2)
REQ-031 SHALL cover: ADD 0xFFFF + 0x0001, Cin=0 -> two cycles later Sum = 0x0000, CO = 1, OVF = 0.
REQ-032 SHALL cover: ADD 0x7FFF + 0x0001 -> Sum = 0x8000, CO = 0, OVF = 1; SUB 0x0005 - 0x0007 -> Sum = 0xFFFE, CO = 0, OVF = 0.
REQ-033 SHALL cover: 8 back-to-back ADDs with out_ready = 1 -> 8 results on consecutive cycles, in order, first at cycle 2.
REQ-034 SHALL cover: out_ready low for 3 cycles with pipe full -> in_ready = 0, outputs held, no result lost or duplicated after release.
REQ-035 SHALL cover: Reset_n pulsed low mid-stream -> out_valid = 0 immediately; no stale result emerges afterward.
REQ-036 SHALL cover: Clear asserted together with in_valid -> input dropped, out_valid = 0 next cycle.
